peripheral_master_wb: RTL

Synthesizable Wishbone B3 master engine that turns single commands into classic single or incrementing-burst bus cycles. It is the initiating end of the peripheral Wishbone bus, driving the same slave-side signal set that the slave bus-functional model responds to. Write data enters through a valid/ready stream, read data leaves as a qualified pulse stream, and a done/err strobe ends each command.

---
 rtl/peripheral_master_wb_if.sv | 64 ++++++
 rtl/peripheral_master_wb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_master_wb_if.sv
// Signal bundle for peripheral_master_wb: command, write-data stream,
// read-data stream, completion strobe and the Wishbone master bus.
//   master modport : the engine (drives cmd_ready, wdat_ready, rdat*,
//                    done*, wb_*_o; samples cmd_*, wdat*, wb_*_i)
//   slave modport  : the peer (command source, data source/sink, slave)
interface peripheral_master_wb_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int LW = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_adr;
    logic [DW/8-1:0] cmd_sel;
    logic [LW-1:0]   cmd_len;

    logic            wdat_valid;
    logic            wdat_ready;
    logic [DW-1:0]   wdat;

    logic            rdat_valid;
    logic [DW-1:0]   rdat;

    logic            done;
    logic            done_err;

    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
        output cmd_ready,
        input  wdat_valid, wdat,
        output wdat_ready,
        output rdat_valid, rdat,
        output done, done_err,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        output wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
        input  cmd_ready,
        output wdat_valid, wdat,
        input  wdat_ready,
        input  rdat_valid, rdat,
        input  done, done_err,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        input  wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/peripheral_master_wb.sv
// Wishbone B3 master engine: one command becomes a classic single or
// incrementing-burst cycle. Write beats come in on a valid/ready stream,
// read beats leave as rdat_valid pulses, done/done_err close each command.
// Ports:
//   wb_clk   : clock, rising edge
//   wb_rst_n : asynchronous active-low reset
//   bus      : peripheral_master_wb_if.master (cmd_*, wdat*, rdat*,
//              done*, wb_*)
// Optional watchdog: define PERIPHERAL_WB_MASTER_TIMEOUT_EN to end a beat
// with an error after TIMEOUT strobe cycles without any response.
module peripheral_master_wb #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int LW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    peripheral_master_wb_if.master bus
);
    localparam int SW = DW / 8;
    localparam logic [AW-1:0] STEP = AW'(SW);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_BUS,
        S_RTY,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state;

    logic [LW-1:0]   r_beats;
    logic [LW-1:0]   w_beats;
    logic            r_cmd_ready;
    logic            w_cmd_ready;
    logic            r_wdat_ready;
    logic            w_wdat_ready;
    logic            r_rdat_valid;
    logic            w_rdat_valid;
    logic [DW-1:0]   r_rdat;
    logic [DW-1:0]   w_rdat;
    logic            r_done;
    logic            w_done;
    logic            r_done_err;
    logic            w_done_err;
    logic [AW-1:0]   r_adr;
    logic [AW-1:0]   w_adr;
    logic [DW-1:0]   r_dat;
    logic [DW-1:0]   w_dat;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   w_sel;
    logic            r_we;
    logic            w_we;
    logic            r_cyc;
    logic            w_cyc;
    logic            r_stb;
    logic            w_stb;
    logic [2:0]      r_cti;
    logic [2:0]      w_cti;

    logic            w_tmo;
    logic            w_fail;

`ifdef PERIPHERAL_WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0]   r_wdog;
    logic            w_resp;

    assign w_resp = bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i;

    // Fires on the TIMEOUT-th silent strobe cycle of a beat.
    assign w_tmo = (r_state == S_BUS) && !w_resp &&
                   (r_wdog == TW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_wdog <= '0;
        end else if (r_state != S_BUS || w_resp) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + TW'(1);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    assign w_fail = bus.wb_err_i | w_tmo;

    // Next-state and next-output logic; every output is a register.
    always_comb begin
        w_state      = r_state;
        w_beats      = r_beats;
        w_cmd_ready  = r_cmd_ready;
        w_wdat_ready = r_wdat_ready;
        w_rdat_valid = 1'b0;
        w_rdat       = r_rdat;
        w_done       = 1'b0;
        w_done_err   = 1'b0;
        w_adr        = r_adr;
        w_dat        = r_dat;
        w_sel        = r_sel;
        w_we         = r_we;
        w_cyc        = r_cyc;
        w_stb        = r_stb;
        w_cti        = r_cti;

        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_we        = bus.cmd_we;
                    w_adr       = bus.cmd_adr;
                    w_sel       = bus.cmd_sel;
                    w_beats     = bus.cmd_len;
                    w_cmd_ready = 1'b0;
                    w_cyc       = 1'b1;
                    w_cti       = (bus.cmd_len == '0) ? CTI_CLASSIC
                                                      : CTI_INCR;
                    if (bus.cmd_we) begin
                        w_state      = S_WDATA;
                        w_wdat_ready = 1'b1;
                    end else begin
                        w_state = S_BUS;
                        w_stb   = 1'b1;
                    end
                end
            end

            S_WDATA: begin
                if (bus.wdat_valid) begin
                    w_dat        = bus.wdat;
                    w_wdat_ready = 1'b0;
                    w_stb        = 1'b1;
                    w_state      = S_BUS;
                end
            end

            S_BUS: begin
                if (w_fail) begin
                    w_state    = S_DONE;
                    w_cyc      = 1'b0;
                    w_stb      = 1'b0;
                    w_cti      = CTI_CLASSIC;
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end else if (bus.wb_ack_i) begin
                    if (!r_we) begin
                        w_rdat       = bus.wb_dat_i;
                        w_rdat_valid = 1'b1;
                    end
                    if (r_beats == '0) begin
                        w_state = S_DONE;
                        w_cyc   = 1'b0;
                        w_stb   = 1'b0;
                        w_cti   = CTI_CLASSIC;
                        w_done  = 1'b1;
                    end else begin
                        w_adr   = r_adr + STEP;
                        w_beats = r_beats - LW'(1);
                        w_cti   = (r_beats == LW'(1)) ? CTI_END
                                                      : CTI_INCR;
                        // Writes fetch the next beat before strobing.
                        if (r_we) begin
                            w_state      = S_WDATA;
                            w_stb        = 1'b0;
                            w_wdat_ready = 1'b1;
                        end
                    end
                end else if (bus.wb_rty_i) begin
                    w_state = S_RTY;
                    w_stb   = 1'b0;
                end
            end

            // One idle strobe cycle, then the same beat again.
            S_RTY: begin
                w_state = S_BUS;
                w_stb   = 1'b1;
            end

            S_DONE: begin
                w_state     = S_IDLE;
                w_cmd_ready = 1'b1;
            end

            default: begin
                w_state     = S_IDLE;
                w_cmd_ready = 1'b1;
                w_cyc       = 1'b0;
                w_stb       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state      <= S_IDLE;
            r_beats      <= '0;
            r_cmd_ready  <= 1'b1;
            r_wdat_ready <= 1'b0;
            r_rdat_valid <= 1'b0;
            r_rdat       <= '0;
            r_done       <= 1'b0;
            r_done_err   <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_cti        <= '0;
        end else begin
            r_state      <= w_state;
            r_beats      <= w_beats;
            r_cmd_ready  <= w_cmd_ready;
            r_wdat_ready <= w_wdat_ready;
            r_rdat_valid <= w_rdat_valid;
            r_rdat       <= w_rdat;
            r_done       <= w_done;
            r_done_err   <= w_done_err;
            r_adr        <= w_adr;
            r_dat        <= w_dat;
            r_sel        <= w_sel;
            r_we         <= w_we;
            r_cyc        <= w_cyc;
            r_stb        <= w_stb;
            r_cti        <= w_cti;
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.wdat_ready = r_wdat_ready;
    assign bus.rdat_valid = r_rdat_valid;
    assign bus.rdat       = r_rdat;
    assign bus.done       = r_done;
    assign bus.done_err   = r_done_err;
    assign bus.wb_adr_o   = r_adr;
    assign bus.wb_dat_o   = r_dat;
    assign bus.wb_sel_o   = r_sel;
    assign bus.wb_we_o    = r_we;
    assign bus.wb_cyc_o   = r_cyc;
    assign bus.wb_stb_o   = r_stb;
    assign bus.wb_cti_o   = r_cti;
    assign bus.wb_bte_o   = 2'b00;
endmodule
